// File: rtl/score_pkg.sv
// Shared constants for the score counter: saturation ceiling, combo tiers and
// the points awarded per tier.
package score_pkg;

    localparam int MAX_SCORE_DEF = 9999;
    localparam int COMBO_W       = 7;
    localparam int POINTS_W      = 3;

    localparam logic [COMBO_W-1:0] TIER1_MIN = 7'd10;
    localparam logic [COMBO_W-1:0] TIER2_MIN = 7'd20;
    localparam logic [COMBO_W-1:0] TIER3_MIN = 7'd50;

    localparam logic [POINTS_W-1:0] MULT_T0 = 3'd1;
    localparam logic [POINTS_W-1:0] MULT_T1 = 3'd2;
    localparam logic [POINTS_W-1:0] MULT_T2 = 3'd3;
    localparam logic [POINTS_W-1:0] MULT_T3 = 3'd5;

    typedef enum logic [1:0] {
        TIER_0,
        TIER_1,
        TIER_2,
        TIER_3
    } tier_e;

    function automatic tier_e tier_of(input logic [COMBO_W-1:0] combo);
        tier_e t;
        t = TIER_0;
        if (combo >= TIER3_MIN)      t = TIER_3;
        else if (combo >= TIER2_MIN) t = TIER_2;
        else if (combo >= TIER1_MIN) t = TIER_1;
        return t;
    endfunction

endpackage

// File: rtl/score_multiplier.sv
// Combinational tier lookup: maps the current combo count to the points a
// hit at that combo is worth.
module score_multiplier
    import score_pkg::*;
(
    input  logic [COMBO_W-1:0]  combo_i,
    output logic [POINTS_W-1:0] points_o
);

    tier_e tier;

    always_comb begin
        tier = tier_of(combo_i);
        unique case (tier)
            TIER_0:  points_o = MULT_T0;
            TIER_1:  points_o = MULT_T1;
            TIER_2:  points_o = MULT_T2;
            TIER_3:  points_o = MULT_T3;
            default: points_o = MULT_T0;
        endcase
    end

endmodule

// File: rtl/score_counter.sv
// Saturating score accumulator: awards tier points whenever the combo count
// rises, clamping at MAX_SCORE until the next reset.
module score_counter
    import score_pkg::*;
#(
    parameter  int MAX_SCORE   = MAX_SCORE_DEF,
    localparam int SCORE_WIDTH = $clog2(MAX_SCORE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COMBO_W-1:0]     combo_count,
    output logic [SCORE_WIDTH-1:0] score_count
);

    // Sum is one bit wider than the score; for tiny ceilings it must still
    // hold the largest points value, so never narrower than POINTS_W + 1.
    localparam int SUM_W = ((SCORE_WIDTH > POINTS_W) ? SCORE_WIDTH : POINTS_W) + 1;
    localparam logic [SUM_W-1:0]       MAX_SUM = SUM_W'(MAX_SCORE);
    localparam logic [SCORE_WIDTH-1:0] MAX_VAL = SCORE_WIDTH'(MAX_SCORE);

    logic [COMBO_W-1:0]     prev_combo_q;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [POINTS_W-1:0]    points;
    logic [SUM_W-1:0]       sum;
    logic                   hit;

    score_multiplier u_mult (
        .combo_i  (combo_count),
        .points_o (points)
    );

    // A drop or a repeat is a miss/idle cycle; only a rise earns points,
    // and a multi-step jump still earns a single award.
    always_comb begin
        hit     = (combo_count > prev_combo_q);
        sum     = SUM_W'(score_q) + SUM_W'(points);
        score_d = score_q;
        if (hit) begin
            score_d = (sum > MAX_SUM) ? MAX_VAL : sum[SCORE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_combo_q <= '0;
            score_q      <= '0;
        end else begin
            prev_combo_q <= combo_count;
            score_q      <= score_d;
        end
    end

    assign score_count = score_q;

endmodule

// File: tb/tb_score_counter.sv
// Scoreboard bench for score_counter: a reference model pushes the expected
// score per driven edge; the sampled DUT output is popped and compared.
module tb_score_counter;

    localparam int MAX = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  combo_count = 7'd0;
    logic [13:0] score_count;

    int errors = 0;
    int checks = 0;
    int m_prev = 0;
    int m_score = 0;
    int exp_q[$];

    score_counter dut (
        .clk         (clk),
        .rst         (rst),
        .combo_count (combo_count),
        .score_count (score_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pts(input int c);
        if (c >= 50) return 5;
        if (c >= 20) return 3;
        if (c >= 10) return 2;
        return 1;
    endfunction

    // One clock edge: drive, advance the model, then compare the popped entry.
    task automatic step(input logic r, input int c, input string tag);
        int e;
        @(negedge clk);
        rst = r;
        combo_count = 7'(c);
        if (!r) begin
            m_prev  = 0;
            m_score = 0;
        end else begin
            if (c > m_prev) begin
                m_score = m_score + pts(c);
                if (m_score > MAX) m_score = MAX;
            end
            m_prev = c;
        end
        exp_q.push_back(m_score);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(tag, 32'(score_count), 32'(e));
    endtask

    task automatic ramp(input string tag);
        for (int i = 0; i < 100; i++) step(1'b1, i, tag);
    endtask

    initial begin
        // Reset with combo held high; the first released edge sees prev=0.
        step(1'b0, 37, "rst_hold");
        chk("rst_zero", 32'(score_count), 32'd0);
        step(1'b1, 37, "rel_first");
        chk("rel_first_abs", 32'(score_count), 32'd3);
        step(1'b1, 37, "steady");
        step(1'b1, 37, "steady");
        chk("steady_abs", 32'(score_count), 32'd3);

        // Short ramp through the first tier boundary.
        step(1'b0, 0, "rst");
        for (int i = 1; i <= 10; i++) step(1'b1, i, "ramp10");
        chk("ramp10_abs", 32'(score_count), 32'd11);

        // Full ramp and wrap.
        step(1'b0, 0, "rst");
        ramp("ramp100");
        chk("ramp100_abs", 32'(score_count), 32'd369);
        step(1'b1, 0, "wrap");
        chk("wrap_abs", 32'(score_count), 32'd369);

        // Large jump earns one award; a drop earns nothing.
        step(1'b0, 0, "rst");
        step(1'b1, 0, "jump0");
        step(1'b1, 60, "jump60");
        chk("jump_abs", 32'(score_count), 32'd5);
        step(1'b1, 3, "drop3");
        chk("drop_abs", 32'(score_count), 32'd5);
        step(1'b1, 127, "top");
        step(1'b1, 127, "top_hold");
        chk("top_abs", 32'(score_count), 32'd10);

        // Saturation.
        step(1'b0, 0, "rst");
        for (int r = 0; r < 28; r++) ramp("sat_ramp");
        chk("sat_abs", 32'(score_count), 32'd9999);
        ramp("sat_hold");
        chk("sat_hold_abs", 32'(score_count), 32'd9999);

        // Mid-operation reset while climbing above 2000.
        step(1'b0, 0, "rst");
        for (int r = 0; r < 6; r++) ramp("pre_mid");
        for (int i = 0; i < 50; i++) step(1'b1, i, "pre_mid");
        chk("pre_mid_gt2000", 32'(score_count > 14'd2000), 32'd1);
        step(1'b0, 51, "mid_rst");
        chk("mid_rst_abs", 32'(score_count), 32'd0);
        step(1'b1, 25, "post_rst");
        chk("post_rst_abs", 32'(score_count), 32'd3);

        // Random walk with occasional resets.
        for (int i = 0; i < 400; i++) begin
            int c;
            logic r;
            r = ($urandom_range(0, 39) != 0);
            c = (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                             : ((m_prev + 1) % 128));
            step(r, c, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
